// File: rtl/dmem_resp_pkg.sv
// rtl/dmem_resp_pkg.sv - shared core constants: RV32I load/store size codes and responder FSM states
package dmem_resp_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - DEPTH_WORDS x 32 synchronous RAM, byte write enables, registered read port
module dmem_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Read data holds its value while en is low, so a response can sit in RESP indefinitely.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - fixed-latency load/store responder in front of a local data RAM
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

  dmem_state_t state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        go_resp;

  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  f3_q;

  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata;
  logic [2:0]  cur_f3;
  logic        err;

  logic        ram_en;
  logic [3:0]  be, ram_we;
  logic [31:0] wdata_al, ram_rdata, load_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // With LATENCY=1 the RAM access happens on the accept edge, before the request is latched.
  always_comb begin
    if (state == ST_IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_f3    = req_funct3;
      cur_wdata = req_wdata;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_f3    = f3_q;
      cur_wdata = wdata_q;
    end
  end

  always_comb begin
    err = 1'b0;
    case (cur_f3)
      F3_B, F3_BU: err = 1'b0;
      F3_H, F3_HU: err = cur_addr[0];
      F3_W:        err = |cur_addr[1:0];
      default:     err = 1'b1;
    endcase
    if ((cur_f3 == F3_BU || cur_f3 == F3_HU) && cur_we) err = 1'b1;
    if (cur_addr >= ADDR_LIMIT) err = 1'b1;
  end

  always_comb begin
    be       = 4'b1111;
    wdata_al = cur_wdata;
    case (cur_f3[1:0])
      2'b00: begin
        be       = 4'b0001 << cur_addr[1:0];
        wdata_al = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be       = cur_addr[1] ? 4'b1100 : 4'b0011;
        wdata_al = {2{cur_wdata[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        wdata_al = cur_wdata;
      end
    endcase
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    go_resp = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_d = ST_RESP;
            go_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt - 4'd1;
        if (cnt_d == 4'd0) begin
          state_d = ST_RESP;
          go_resp = 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == ST_IDLE && req_valid) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      f3_q    <= req_funct3;
      wdata_q <= req_wdata;
    end
  end

  // Reset on the transition edge must suppress the store, hence the rst gate.
  assign ram_en = go_resp && !err && !rst;
  assign ram_we = (ram_en && cur_we) ? be : 4'b0000;

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (cur_addr[AW+1:2]),
    .wdata (wdata_al),
    .rdata (ram_rdata)
  );

  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = ram_rdata[7:0];
      2'd1:    lane_b = ram_rdata[15:8];
      2'd2:    lane_b = ram_rdata[23:16];
      default: lane_b = ram_rdata[31:24];
    endcase
    lane_h = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (f3_q)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_data = {24'd0, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_data = {16'd0, lane_h};
      default: load_data = ram_rdata;
    endcase
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = resp_valid && err;
  assign resp_rdata = (resp_valid && !err && !we_q) ? load_data : 32'd0;

endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - scoreboard bench for dmem_resp at LATENCY=2 and LATENCY=1
module tb_dmem_resp;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid_1 = 1'b0, req_ready_1, req_we_1 = 1'b0;
  logic [31:0] req_addr_1 = '0, req_wdata_1 = '0;
  logic [2:0]  req_funct3_1 = '0;
  logic        resp_valid_1, resp_ready_1 = 1'b1, resp_err_1;
  logic [31:0] resp_rdata_1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [32:0] exp_q[$];
  logic [32:0] exp_q1[$];
  logic [31:0] mdl[int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_resp #(.DEPTH_WORDS(256), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_resp #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_1), .req_ready(req_ready_1), .req_we(req_we_1),
    .req_addr(req_addr_1), .req_funct3(req_funct3_1), .req_wdata(req_wdata_1),
    .resp_valid(resp_valid_1), .resp_ready(resp_ready_1),
    .resp_rdata(resp_rdata_1), .resp_err(resp_err_1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference memory model: byte-level update / extract on a word array.
  task automatic model(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wdata, input bit commit,
                       output logic [31:0] exp_rd, output logic exp_err);
    int nb = 4;
    bit sgn = 1'b0;
    int a;
    int idx;
    logic [31:0] w;
    logic [31:0] mask;
    exp_rd  = '0;
    exp_err = 1'b0;
    case (f3)
      3'b000:  begin nb = 1; sgn = 1'b1; end
      3'b001:  begin nb = 2; sgn = 1'b1; end
      3'b010:  begin nb = 4; sgn = 1'b0; end
      3'b100:  begin nb = 1; sgn = 1'b0; exp_err = we; end
      3'b101:  begin nb = 2; sgn = 1'b0; exp_err = we; end
      default: begin nb = 4; exp_err = 1'b1; end
    endcase
    a = int'(addr[1:0]);
    if (a % nb != 0) exp_err = 1'b1;
    if (addr >= 32'h400) exp_err = 1'b1;
    if (!exp_err) begin
      idx = int'(addr[9:2]);
      w = mdl.exists(idx) ? mdl[idx] : 32'd0;
      if (we) begin
        for (int j = 0; j < nb; j++) w[8*(a+j) +: 8] = wdata[8*j +: 8];
        if (commit) mdl[idx] = w;
      end else begin
        exp_rd = w >> (8 * a);
        if (nb < 4) begin
          mask = (32'h1 << (8 * nb)) - 32'h1;
          exp_rd = exp_rd & mask;
          if (sgn && exp_rd[8*nb-1]) exp_rd = exp_rd | ~mask;
        end
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"},  32'(req_ready),  32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata,      32'd0);
    check({tag, "_resp_err"},   32'(resp_err),   32'd0);
  endtask

  task automatic xfer(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                      input logic [31:0] wdata, input int hold, input bit do_rst);
    logic [31:0] er;
    logic        ee;
    logic [32:0] e;
    int n;
    model(we, addr, f3, wdata, !do_rst, er, ee);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    if (do_rst) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_state("rst_wait");
      return;
    end
    exp_q.push_back({ee, er});
    n = 1;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) begin
      check("resp_timeout", 32'(resp_valid), 32'd1);
      void'(exp_q.pop_front());
      return;
    end
    check("latency", 32'(n), 32'(LAT));
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, exp_q[0][31:0]);
      check("hold_err", 32'(resp_err), 32'(exp_q[0][32]));
      check("hold_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    e = exp_q.pop_front();
    check("rdata", resp_rdata, e[31:0]);
    check("err", 32'(resp_err), 32'(e[32]));
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic        t_we  [6];
    logic [31:0] t_addr[6];
    logic [2:0]  t_f3  [6];
    logic [31:0] t_wd  [6];
    logic [31:0] t_exp [6];
    logic [32:0] e1;
    int k;
    int last;

    t_we  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    t_addr= '{32'h40, 32'h44, 32'h4A, 32'h40, 32'h44, 32'h4A};
    t_f3  = '{3'b010, 3'b010, 3'b001, 3'b010, 3'b010, 3'b001};
    t_wd  = '{32'hA1A2A3A4, 32'h0BADF00D, 32'h00008001, 32'h0, 32'h0, 32'h0};
    t_exp = '{32'h0, 32'h0, 32'h0, 32'hA1A2A3A4, 32'h0BADF00D, 32'hFFFF8001};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    xfer(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 0, 1'b0);
    xfer(1'b0, 32'h10, 3'b010, 32'h0, 0, 1'b0);
    xfer(1'b1, 32'h13, 3'b000, 32'h00000080, 0, 1'b0);
    xfer(1'b0, 32'h13, 3'b000, 32'h0, 0, 1'b0);
    xfer(1'b0, 32'h13, 3'b100, 32'h0, 0, 1'b0);
    xfer(1'b0, 32'h10, 3'b010, 32'h0, 0, 1'b0);
    xfer(1'b0, 32'h11, 3'b001, 32'h0, 0, 1'b0);
    xfer(1'b1, 32'h0,  3'b010, 32'h11223344, 0, 1'b0);
    xfer(1'b1, 32'h400, 3'b010, 32'hFFFFFFFF, 0, 1'b0);
    xfer(1'b0, 32'h0,  3'b010, 32'h0, 0, 1'b0);
    xfer(1'b1, 32'h16, 3'b001, 32'h0000A5C3, 0, 1'b0);
    xfer(1'b0, 32'h16, 3'b001, 32'h0, 0, 1'b0);
    xfer(1'b0, 32'h16, 3'b101, 32'h0, 0, 1'b0);
    xfer(1'b0, 32'h14, 3'b011, 32'h0, 0, 1'b0);
    xfer(1'b1, 32'h14, 3'b100, 32'h55, 0, 1'b0);
    xfer(1'b0, 32'h12, 3'b010, 32'h0, 0, 1'b0);
    xfer(1'b0, 32'h10, 3'b010, 32'h0, 5, 1'b0);
    xfer(1'b1, 32'h20, 3'b010, 32'hCAFEF00D, 0, 1'b0);
    xfer(1'b1, 32'h20, 3'b010, 32'h12345678, 0, 1'b1);
    xfer(1'b0, 32'h20, 3'b010, 32'h0, 0, 1'b0);

    k = 0;
    last = 0;
    for (int c = 0; c < 40 && (k < 6 || exp_q1.size() > 0); c++) begin
      @(negedge clk);
      if (resp_valid_1 && exp_q1.size() > 0) begin
        e1 = exp_q1.pop_front();
        check("l1_rdata", resp_rdata_1, e1[31:0]);
        check("l1_err", 32'(resp_err_1), 32'(e1[32]));
      end
      if (req_ready_1 && k < 6) begin
        if (k > 0) check("l1_accept_gap", 32'(cyc - last), 32'd2);
        last = cyc;
        req_valid_1 = 1'b1; req_we_1 = t_we[k]; req_addr_1 = t_addr[k];
        req_funct3_1 = t_f3[k]; req_wdata_1 = t_wd[k];
        exp_q1.push_back({1'b0, t_exp[k]});
        k++;
      end
    end
    req_valid_1 = 1'b0;
    check("l1_issued", 32'(k), 32'd6);
    check("l1_drained", 32'(exp_q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
